// File: rtl/slurm32_cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, shift-sequencer op encodings and state type.
package slurm32_cpu_pkg;

  localparam logic [4:0] ALU_MOV  = 5'd0;
  localparam logic [4:0] ALU_RRN  = 5'd10;
  localparam logic [4:0] ALU_ASR  = 5'd16;
  localparam logic [4:0] ALU_LSR  = 5'd17;
  localparam logic [4:0] ALU_LSL  = 5'd18;
  localparam logic [4:0] ALU_ROLC = 5'd19;
  localparam logic [4:0] ALU_RORC = 5'd20;
  localparam logic [4:0] ALU_ROL  = 5'd21;
  localparam logic [4:0] ALU_ROR  = 5'd22;

  localparam logic [2:0] SEQ_OP_LSL  = 3'd0;
  localparam logic [2:0] SEQ_OP_LSR  = 3'd1;
  localparam logic [2:0] SEQ_OP_ASR  = 3'd2;
  localparam logic [2:0] SEQ_OP_ROL  = 3'd3;
  localparam logic [2:0] SEQ_OP_ROR  = 3'd4;
  localparam logic [2:0] SEQ_OP_ROLC = 3'd5;
  localparam logic [2:0] SEQ_OP_RORC = 3'd6;
  localparam logic [2:0] SEQ_OP_RRN  = 3'd7;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_STEP  = 2'd1,
    SEQ_DRAIN = 2'd2,
    SEQ_DONE  = 2'd3
  } seqState_t;

  // Single-bit ALU opcode issued for each sequencer operation.
  function automatic logic [4:0] seqAluOp(input logic [2:0] opSel);
    logic [4:0] aluOp;
    case (opSel)
      SEQ_OP_LSL:  aluOp = ALU_LSL;
      SEQ_OP_LSR:  aluOp = ALU_LSR;
      SEQ_OP_ASR:  aluOp = ALU_ASR;
      SEQ_OP_ROL:  aluOp = ALU_ROL;
      SEQ_OP_ROR:  aluOp = ALU_ROR;
      SEQ_OP_ROLC: aluOp = ALU_ROLC;
      SEQ_OP_RORC: aluOp = ALU_RORC;
      SEQ_OP_RRN:  aluOp = ALU_RRN;
      default:     aluOp = ALU_MOV;
    endcase
    return aluOp;
  endfunction

endpackage

// File: rtl/slurm32_cpu_shift_seq.sv
// Multi-bit shift/rotate sequencer: borrows the execute-stage ALU for N single-bit steps,
// chaining the ALU's registered result back into operand B each cycle.
module slurm32_cpu_shift_seq
  import slurm32_cpu_pkg::*;
#(
  parameter int BITS     = 32,
  parameter int AMT_BITS = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic                abort,
  input  logic [2:0]          op_sel,
  input  logic [BITS-1:0]     operand,
  input  logic [AMT_BITS-1:0] amount,
  output logic                busy,
  output logic                done,
  output logic [BITS-1:0]     result,
  output logic                alu_own,
  output logic [4:0]          alu_op,
  output logic [BITS-1:0]     alu_a,
  output logic [BITS-1:0]     alu_b,
  input  logic [BITS-1:0]     alu_out
);

  seqState_t           state_r;
  logic [2:0]          opSel_r;
  logic [BITS-1:0]     operand_r;
  logic [AMT_BITS-1:0] cnt_r;
  logic                first_r;
  logic [BITS-1:0]     result_r;

  logic                busy_s;
  logic                done_s;
  logic                aluOwn_s;
  logic [4:0]          aluOp_s;
  logic [BITS-1:0]     aluB_s;

  // Sequencer state, latched request and step counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= SEQ_IDLE;
      opSel_r   <= 3'd0;
      operand_r <= {BITS{1'b0}};
      cnt_r     <= {AMT_BITS{1'b0}};
      first_r   <= 1'b0;
      result_r  <= {BITS{1'b0}};
    end else if (abort) begin
      // Flush: drop the operation, leave the previous result visible.
      state_r <= SEQ_IDLE;
      first_r <= 1'b0;
    end else begin
      case (state_r)
        SEQ_IDLE: begin
          if (start) begin
            opSel_r   <= op_sel;
            operand_r <= operand;
            if (amount == {AMT_BITS{1'b0}}) begin
              result_r <= operand;
              state_r  <= SEQ_DONE;
            end else begin
              cnt_r   <= amount;
              first_r <= 1'b1;
              state_r <= SEQ_STEP;
            end
          end else begin
            state_r <= SEQ_IDLE;
          end
        end
        SEQ_STEP: begin
          first_r <= 1'b0;
          cnt_r   <= cnt_r - AMT_BITS'(1);
          if (cnt_r == AMT_BITS'(1)) begin
            state_r <= SEQ_DRAIN;
          end else begin
            state_r <= SEQ_STEP;
          end
        end
        SEQ_DRAIN: begin
          // The last step's result appears on alu_out one cycle after it was issued.
          result_r <= alu_out;
          state_r  <= SEQ_DONE;
        end
        SEQ_DONE: begin
          state_r <= SEQ_IDLE;
        end
        default: begin
          state_r <= SEQ_IDLE;
        end
      endcase
    end
  end

  // Output decode from the registered state; operand B chains through alu_out after the first step.
  always_comb begin
    busy_s   = 1'b0;
    done_s   = 1'b0;
    aluOwn_s = 1'b0;
    aluOp_s  = ALU_MOV;
    aluB_s   = {BITS{1'b0}};
    case (state_r)
      SEQ_IDLE: begin
        busy_s = 1'b0;
      end
      SEQ_STEP: begin
        busy_s   = 1'b1;
        aluOwn_s = 1'b1;
        aluOp_s  = seqAluOp(opSel_r);
        if (first_r) begin
          aluB_s = operand_r;
        end else begin
          aluB_s = alu_out;
        end
      end
      SEQ_DRAIN: begin
        // mov keeps the flags produced by the final shift step.
        busy_s   = 1'b1;
        aluOwn_s = 1'b1;
        aluOp_s  = ALU_MOV;
        aluB_s   = alu_out;
      end
      SEQ_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign busy    = busy_s;
  assign done    = done_s;
  assign result  = result_r;
  assign alu_own = aluOwn_s;
  assign alu_op  = aluOp_s;
  assign alu_a   = {BITS{1'b0}};
  assign alu_b   = aluB_s;

endmodule

// File: tb/tb_slurm32_cpu_shift_seq.sv
// Bench for slurm32_cpu_shift_seq: bench-side ALU plus closed-form shift reference model.
module tb_slurm32_cpu_shift_seq;
  import slurm32_cpu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic        abort;
  logic [2:0]  op_sel;
  logic [31:0] operand;
  logic [4:0]  amount;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        alu_own;
  logic [4:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;

  logic zFlag, cFlag;
  logic aluLoad, loadZ, loadC;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] lastResult;

  always #5 CLK = ~CLK;

  slurm32_cpu_shift_seq #(.BITS(32), .AMT_BITS(5)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .op_sel(op_sel),
    .operand(operand), .amount(amount), .busy(busy), .done(done), .result(result),
    .alu_own(alu_own), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
  );

  // One ALU step as the execute stage performs it: returns {Z, C, result}.
  function automatic logic [33:0] aluStep(input logic [4:0] op, input logic [31:0] b,
                                          input logic z, input logic c);
    logic [31:0] r;
    logic nz, nc;
    r = b; nz = z; nc = c;
    case (op)
      ALU_LSL:  begin r = {b[30:0], 1'b0}; nz = (r == 32'd0); end
      ALU_LSR:  begin r = {1'b0, b[31:1]}; nz = (r == 32'd0); end
      ALU_ASR:  begin r = {b[31], b[31:1]}; nz = (r == 32'd0); end
      ALU_ROL:  r = {b[30:0], b[31]};
      ALU_ROR:  r = {b[0], b[31:1]};
      ALU_ROLC: begin r = {b[30:0], c}; nc = b[31]; end
      ALU_RORC: begin r = {c, b[31:1]}; nc = b[0]; end
      ALU_RRN:  r = {b[3:0], b[31:4]};
      default:  r = b;
    endcase
    return {nz, nc, r};
  endfunction

  always @(posedge CLK) begin
    if (RST) alu_out <= 32'd0;
    else if (alu_own) {zFlag, cFlag, alu_out} <= aluStep(alu_op, alu_b, zFlag, cFlag);
    if (aluLoad) begin zFlag <= loadZ; cFlag <= loadC; end
  end

  // Whole-operation reference: returns {carry out, result} of shifting x by n.
  function automatic logic [32:0] refShift(input logic [2:0] op, input logic [31:0] x,
                                           input int n, input logic cin);
    logic [31:0] r;
    logic [32:0] v, w;
    int rr;
    r = x;
    v = {cin, x};
    w = v;
    case (op)
      3'd0: r = x << n;
      3'd1: r = x >> n;
      3'd2: r = $signed(x) >>> n;
      3'd3: r = (x << n) | (x >> (32 - n));
      3'd4: r = (x >> n) | (x << (32 - n));
      3'd5: w = (v << n) | (v >> (33 - n));
      3'd6: w = (v >> n) | (v << (33 - n));
      default: begin
        rr = (4 * n) % 32;
        r = (x >> rr) | (x << (32 - rr));
      end
    endcase
    if (op == 3'd5 || op == 3'd6) return w;
    return {cin, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic loadFlags(input logic z, input logic c);
    @(negedge CLK);
    aluLoad = 1'b1; loadZ = z; loadC = c;
    @(negedge CLK);
    aluLoad = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] x,
                       input int n, input logic z0, input logic c0,
                       input int abortAt, input int startAt);
    logic [32:0] exp;
    logic expZ, expC;
    int own, doneAt, busyBad, aBad;
    loadFlags(z0, c0);
    @(negedge CLK);
    start = 1'b1; op_sel = op; operand = x; amount = 5'(n);
    @(posedge CLK);
    #1;
    start = 1'b0; op_sel = 3'($urandom); operand = $urandom; amount = 5'($urandom);
    own = 0; doneAt = 0; busyBad = 0; aBad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (alu_own === 1'b1) own++;
      if (alu_a !== 32'd0) aBad++;
      if (abortAt == 0 && busy !== 1'b1) busyBad++;
      if (done === 1'b1 && doneAt == 0) doneAt = k;
      if (abortAt != 0 && k == abortAt + 1) begin
        check({name, "/abort_busy"}, 32'(busy), 32'd0);
        check({name, "/abort_own"}, 32'(alu_own), 32'd0);
      end
      if (abortAt == 0 && doneAt != 0) break;
      abort = (k == abortAt);
      start = (k == startAt);
      if (k == startAt) begin operand = ~x; amount = 5'd1; end
    end
    abort = 1'b0;
    start = 1'b0;
    check({name, "/alu_a"}, 32'(aBad), 32'd0);
    if (abortAt == 0) begin
      exp  = refShift(op, x, n, c0);
      expZ = (n > 0 && op <= 3'd2) ? (exp[31:0] == 32'd0) : z0;
      expC = (n > 0 && (op == 3'd5 || op == 3'd6)) ? exp[32] : c0;
      check({name, "/result"}, result, exp[31:0]);
      check({name, "/latency"}, 32'(doneAt), (n == 0) ? 32'd1 : 32'(n + 2));
      check({name, "/own_cycles"}, 32'(own), (n == 0) ? 32'd0 : 32'(n + 1));
      check({name, "/busy"}, 32'(busyBad), 32'd0);
      check({name, "/zflag"}, 32'(zFlag), 32'(expZ));
      check({name, "/cflag"}, 32'(cFlag), 32'(expC));
      @(negedge CLK);
      check({name, "/done_pulse"}, 32'(done), 32'd0);
      check({name, "/idle_busy"}, 32'(busy), 32'd0);
      lastResult = exp[31:0];
    end else begin
      check({name, "/no_done"}, 32'(doneAt), 32'd0);
      check({name, "/result_held"}, result, lastResult);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; start = 1'b0; abort = 1'b0; op_sel = 3'd0; operand = 32'd0; amount = 5'd0;
    aluLoad = 1'b0; loadZ = 1'b0; loadC = 1'b0;
    lastResult = 32'd0;
    repeat (2) @(negedge CLK);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/own", 32'(alu_own), 32'd0);
    check("reset/result", result, 32'd0);
    check("reset/alu_op", 32'(alu_op), 32'd0);
    check("reset/alu_b", alu_b, 32'd0);
    RST = 1'b0;

    runOp("lsl4", SEQ_OP_LSL, 32'h0000_00F1, 4, 1'b1, 1'b0, 0, 0);
    check("lsl4/const", result, 32'h0000_0F10);
    runOp("asr31", SEQ_OP_ASR, 32'h8000_0000, 31, 1'b1, 1'b0, 0, 0);
    check("asr31/const", result, 32'hFFFF_FFFF);
    check("asr31/z", 32'(zFlag), 32'd0);
    runOp("rol8", SEQ_OP_ROL, 32'h1234_5678, 8, 1'b0, 1'b0, 0, 0);
    check("rol8/const", result, 32'h3456_7812);
    runOp("rorc1", SEQ_OP_RORC, 32'h0000_0002, 1, 1'b0, 1'b1, 0, 0);
    check("rorc1/const", result, 32'h8000_0001);
    check("rorc1/c", 32'(cFlag), 32'd0);
    runOp("amt0", 3'($urandom), 32'hDEAD_BEEF, 0, 1'b1, 1'b1, 0, 0);
    check("amt0/const", result, 32'hDEAD_BEEF);
    runOp("rrn8", SEQ_OP_RRN, 32'hCAFE_F00D, 8, 1'b0, 1'b0, 0, 0);
    check("rrn8/identity", result, 32'hCAFE_F00D);
    runOp("rrn3", SEQ_OP_RRN, 32'h1234_5678, 3, 1'b0, 1'b0, 0, 0);
    runOp("lsr10_abort", SEQ_OP_LSR, 32'hF0F0_1234, 10, 1'b0, 1'b0, 3, 0);
    runOp("lsl6_restart", SEQ_OP_LSL, 32'h0001_0203, 6, 1'b0, 1'b0, 0, 2);

    // abort together with start in IDLE: the request must not be taken
    @(negedge CLK);
    start = 1'b1; abort = 1'b1; op_sel = SEQ_OP_LSL; operand = 32'h5555_AAAA; amount = 5'd0;
    @(negedge CLK);
    start = 1'b0; abort = 1'b0;
    check("abort_start/done", 32'(done), 32'd0);
    check("abort_start/busy", 32'(busy), 32'd0);
    check("abort_start/result", result, lastResult);

    // asynchronous reset in the middle of an operation
    @(negedge CLK);
    start = 1'b1; op_sel = SEQ_OP_LSR; operand = 32'hFFFF_0000; amount = 5'd10;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_mid/own_before", 32'(alu_own), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("rst_mid/busy", 32'(busy), 32'd0);
    check("rst_mid/own", 32'(alu_own), 32'd0);
    check("rst_mid/done", 32'(done), 32'd0);
    check("rst_mid/result", result, 32'd0);
    check("rst_mid/alu_op", 32'(alu_op), 32'd0);
    check("rst_mid/alu_b", alu_b, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    lastResult = 32'd0;

    for (int i = 0; i < 24; i++) begin
      runOp("rand", 3'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 31)),
            1'($urandom), 1'($urandom), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
